// File: rtl/user_module_capture_sequencer.sv
// rtl/user_module_capture_sequencer.sv - trigger-armed nibble capture and looped replay on the 8-bit tile I/O.
// Optional SEQ_AUTOREARM_EN: return to ARMED after one full replay pass.
module user_module_capture_sequencer #(
  parameter int DIV   = 4,
  parameter int DEPTH = 4
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam logic [3:0] CNT_LAST = 4'(DIV - 1);
  localparam logic [1:0] IDX_LAST = 2'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, PLAY} state_t;

  logic       clk, rst, arm, trig;
  logic [3:0] din;
  assign clk  = io_in[0];
  assign rst  = io_in[1];
  assign arm  = io_in[2];
  assign trig = io_in[3];
  assign din  = io_in[7:4];

  state_t     state, state_n;
  logic [3:0] cnt;
  logic [1:0] wr, rd;
  // Sized for the largest legal DEPTH; only DEPTH entries are ever addressed.
  logic [3:0] data_buf [4];

  logic step, abort;
  assign step  = (cnt == CNT_LAST);
  assign abort = arm && trig;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (arm) state_n = ARMED;
      ARMED:   if (trig) state_n = CAPTURE;
      CAPTURE: begin
        if (abort)                        state_n = IDLE;
        else if (step && wr == IDX_LAST)  state_n = PLAY;
      end
      PLAY: begin
        if (arm) state_n = ARMED;
`ifdef SEQ_AUTOREARM_EN
        else if (step && rd == IDX_LAST) state_n = ARMED;
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      wr  <= '0;
      rd  <= '0;
      for (int i = 0; i < 4; i++) data_buf[i] <= '0;
    end else begin
      case (state)
        ARMED: if (trig) begin
          data_buf[0] <= din;
          wr          <= 2'd1;
          cnt         <= '0;
        end
        CAPTURE: begin
          if (abort) begin
            cnt <= '0;
            wr  <= '0;
          end else if (step) begin
            data_buf[wr] <= din;
            wr           <= wr + 2'd1;
            cnt          <= '0;
            if (wr == IDX_LAST) rd <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        PLAY: begin
          if (arm) begin
            cnt <= '0;
          end else if (step) begin
            rd  <= (rd == IDX_LAST) ? 2'd0 : rd + 2'd1;
            cnt <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    io_out    = 8'h00;
    io_out[0] = (state == ARMED) || (state == CAPTURE);
    io_out[1] = (state == PLAY);
    if (state == CAPTURE) io_out[3:2] = wr;
    if (state == PLAY) begin
      io_out[3:2] = rd;
      io_out[7:4] = data_buf[rd];
    end
  end

endmodule

// File: tb/tb_user_module_capture_sequencer.sv
// tb/tb_user_module_capture_sequencer.sv - directed-vector bench for the capture sequencer (DIV=4, DEPTH=4).
module tb_user_module_capture_sequencer;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       arm = 1'b0;
  logic       trig = 1'b0;
  logic [3:0] din = 4'h0;
  logic [7:0] io_in;
  logic [7:0] io_out;
  int vectors = 0;
  int miscompares = 0;

  assign io_in = {din, trig, arm, rst, clk};

  user_module_capture_sequencer #(.DIV(4), .DEPTH(4)) dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Trigger at T0 with d0, then one new sample every DIV edges; returns right after edge T0+3*DIV.
  task automatic capture(input logic [3:0] d0, d1, d2, d3);
    logic [3:0] s [4];
    s[0] = d0; s[1] = d1; s[2] = d2; s[3] = d3;
    for (int k = 0; k < 4; k++) begin
      din = s[k];
      if (k == 0) trig = 1'b1;
      step(1);
      trig = 1'b0;
      if (k < 3) step(DIV - 1);
    end
  endtask

  // Expected replay: entry k on data pins, index k, done=1, busy=0, each held DIV cycles.
  task automatic check_replay(input string tag, input logic [3:0] d0, d1, d2, d3, input int cycles);
    logic [3:0] s [4];
    logic [1:0] k;
    s[0] = d0; s[1] = d1; s[2] = d2; s[3] = d3;
    for (int i = 0; i < cycles; i++) begin
      k = 2'((i / DIV) % 4);
      check(tag, io_out, {s[k], k, 2'b10});
      step(1);
    end
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    step(1);
    arm = 1'b0;
  endtask

  initial begin
    #1 check("reset_state", io_out, 8'h00);
    step(1);
    rst = 1'b0;
    step(1);
    check("idle_after_reset", io_out, 8'h00);

    // Basic capture of 3,5,9,C and replay with wrap.
    arm = 1'b1;
    step(1);
    check("armed_busy", io_out, 8'h01);
    arm = 1'b0;
    din = 4'h3;
    trig = 1'b1;
    step(1);
    check("capture_first", io_out, 8'h05);
    trig = 1'b0;
    step(DIV - 1);
    check("capture_hold", io_out, 8'h05);
    for (int k = 1; k < 4; k++) begin
      din = (k == 1) ? 4'h5 : (k == 2) ? 4'h9 : 4'hC;
      step(1);
      if (k < 3) step(DIV - 1);
    end
    check("play_entry", io_out, 8'h32);
    check_replay("replay_basic", 4'h3, 4'h5, 4'h9, 4'hC, 20);

    // arm+trig together in IDLE: arms only.
    rst = 1'b1;
    #1 check("reset_async", io_out, 8'h00);
    step(1);
    rst = 1'b0;
    arm = 1'b1;
    trig = 1'b1;
    din = 4'h7;
    step(1);
    check("idle_arm_trig", io_out, 8'h01);
    arm = 1'b0;
    trig = 1'b0;
    step(2);
    check("armed_stays", io_out, 8'h01);
    capture(4'h1, 4'h2, 4'h4, 4'h8);
    check_replay("replay_after_idle_both", 4'h1, 4'h2, 4'h4, 4'h8, 8);

    // Abort after two samples.
    pulse_arm();
    din = 4'h6;
    trig = 1'b1;
    step(1);
    trig = 1'b0;
    step(DIV - 1);
    din = 4'h7;
    step(1);
    check("capture_two", io_out, 8'h09);
    step(1);
    arm = 1'b1;
    trig = 1'b1;
    step(1);
    check("abort_idle", io_out, 8'h00);
    arm = 1'b0;
    trig = 1'b1;
    step(1);
    check("idle_ignores_trig", io_out, 8'h00);
    trig = 1'b0;
    pulse_arm();
    capture(4'h2, 4'h4, 4'h6, 4'hE);
    check_replay("replay_after_abort", 4'h2, 4'h4, 4'h6, 4'hE, 16);

    // Reset mid-PLAY clears outputs without a clock edge.
    step(2);
    rst = 1'b1;
    #1 check("reset_mid_play", io_out, 8'h00);
    step(1);
    rst = 1'b0;
    din = 4'hF;
    trig = 1'b1;
    step(1);
    check("trig_needs_arm", io_out, 8'h00);
    trig = 1'b0;

    // Arm during PLAY, then overwrite the buffer.
    pulse_arm();
    capture(4'h1, 4'h1, 4'h1, 4'h1);
    check("play_ones", io_out, 8'h12);
    step(5);
    arm = 1'b1;
    step(1);
    check("arm_in_play", io_out, 8'h01);
    arm = 1'b0;
    capture(4'hA, 4'hB, 4'hC, 4'hD);
    check("play_new_entry", io_out, 8'hA2);
    step(DIV - 1);
    check("entry0_held", io_out, 8'hA2);
    step(1);
    check("entry1", io_out, 8'hB6);

    // Auto re-arm versus indefinite replay.
    pulse_arm();
    capture(4'h4, 4'h3, 4'h2, 4'h1);
`ifdef SEQ_AUTOREARM_EN
    step(15);
    check("last_play_cycle", io_out, 8'h1E);
    step(1);
    check("autorearm", io_out, 8'h01);
`else
    step(63);
    check("play_at_63", io_out, 8'h1E);
    step(1);
    check("play_at_64", io_out, 8'h42);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/user_module_capture_sequencer.md
# user_module_capture_sequencer

Trigger-driven capture sequencer for the shared 8-bit tile I/O. It arms on command, waits for a trigger, samples the 4-bit input nibble into a small register buffer at a programmable clock division, then replays the buffer on the output pins. It is the controller that sequences when the DFF capture bank loads and what it drives out, using the same single-clock, io_in/io_out tile wrapper.

## Interface
- DIV, 4: clock cycles between consecutive samples and between replay steps; legal 1..16.
- DEPTH, 4: buffer entries; legal 2 or 4.

- io_in[0]  input  1  clock; all state updates on the rising edge.
- io_in[1]  input  1  reset; asynchronous, active-high.
- io_in[2]  input  1  arm: command to arm, re-arm, or abort.
- io_in[3]  input  1  trig: capture trigger.
- io_in[7:4]  input  4  sample data nibble.
- io_out[0]  output  1  busy: high in ARMED and CAPTURE.
- io_out[1]  output  1  done: high in PLAY.
- io_out[3:2]  output  2  index: write index in CAPTURE, read index in PLAY, 0 otherwise.
- io_out[7:4]  output  4  replay data: buf[rd] in PLAY, 0 otherwise.

## Operation
- States:
  - IDLE: entered from reset.
  - ARMED.
  - CAPTURE.
  - PLAY.
- Registers:
  - state.
  - cnt, 4 bits.
  - wr, 2 bits.
  - rd, 2 bits.
  - buf[DEPTH], 4 bits each.
- All outputs are decoded from registers only. There is no combinational input-to-output path.
- IDLE:
  - arm=1 → ARMED.
  - trig is ignored.
- ARMED:
  - trig=1 → CAPTURE. On the same edge: buf[0] ← io_in[7:4], wr ← 1, cnt ← 0.
  - trig has priority over arm.
  - arm alone is ignored.
- CAPTURE:
  - cnt increments each cycle.
  - When cnt==DIV-1: buf[wr] ← io_in[7:4], wr ← wr+1, cnt ← 0.
  - The edge that writes entry DEPTH-1 also moves to PLAY and sets rd ← 0, cnt ← 0.
  - arm=1 and trig=1 on the same edge aborts to IDLE. buf retains any partial contents; done is not asserted.
  - arm alone or trig alone is ignored.
- PLAY:
  - cnt increments each cycle.
  - When cnt==DIV-1: rd ← (rd+1) mod DEPTH, cnt ← 0.
  - arm=1 → ARMED. This clears done; the buffer is left untouched until the next trigger.
- DIV=1: one sample per cycle; rd advances every cycle.
- With DEPTH=2, io_out[3] is always 0.

## Timing
- Reset values:
  - state=IDLE.
  - cnt=wr=rd=0.
  - all buf entries 0.
  - io_out=8'h00.
- Reset asserted mid-operation forces these values immediately, without waiting for a clock edge.
- Trigger edge T0 captures sample 0. Sample k is captured at edge T0+k·DIV.
- PLAY is entered at edge T0+(DEPTH-1)·DIV. done and buf[0] are visible after that edge.
- Each replay entry is held for exactly DIV cycles. Replay wraps from DEPTH-1 to 0 without a gap.
- Arm-to-ARMED latency: 1 edge. busy rises after the edge on which arm is sampled.
- Abort latency: 1 edge.

## Configuration
- SEQ_AUTOREARM_EN:
  - Defined: after one complete replay pass, the FSM moves to ARMED automatically. The pass is DEPTH·DIV cycles in PLAY, ending on the edge where rd wraps from DEPTH-1 to 0. done drops and busy rises after that edge.
  - Undefined: PLAY loops indefinitely until arm=1 or reset.

## Test plan
- Reset, then arm pulse, then trig at T0 with data 3,5,9,C applied at T0, T0+4, T0+8, T0+12 (DIV=4, DEPTH=4) → after T0+12: done=1, busy=0. io_out[7:4] is 3,5,9,C, each held for 4 cycles, with io_out[3:2] = 0,1,2,3, then wrapping back to 3.
- arm=1 and trig=1 together in IDLE → ARMED only, with no capture. The next trig captures normally.
- arm=1 and trig=1 together during CAPTURE after 2 samples → IDLE, io_out=0. A following arm+trig sequence produces a fresh, correct capture.
- Reset asserted mid-PLAY → io_out=8'h00 immediately. After release, arm is required before any capture.
- Arm during PLAY → done=0, busy=1 on the next edge. A new trig overwrites the buffer with new values A,B,C,D.
- With SEQ_AUTOREARM_EN defined → exactly 16 cycles after PLAY entry: busy=1, done=0, with no arm pulse. Without it, PLAY is still active after 64 cycles.
